// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit
//   EX/MEM data-memory access unit: issues one bus request per load/store,
//   stalls the pipeline until completion and extends returned load data.
//   Optional macro MEM_ACCESS_MISALIGN_TRAP_EN enables misalignment trapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        invalid_in,
    input  logic        memtoreg_in,
    input  logic [3:0]  memwrite_in,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] rdata2_in,
    input  logic [31:0] inst_data_in,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        load_valid_out,
    output logic [31:0] load_data_out,
    output logic        misaligned_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] addr_q,      addr_d;
    logic        we_q,        we_d;
    logic [3:0]  be_q,        be_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [2:0]  funct3_q,    funct3_d;
    logic [1:0]  off_q,       off_d;

    logic        w_is_store;
    logic        w_access;
    logic        w_misalign;
    logic        w_issue;
    logic        w_complete;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [31:0] w_rd_shift;
    logic [31:0] w_rd_ext;
    logic        w_unused_inst;

    assign w_unused_inst = ^{inst_data_in[31:15], inst_data_in[11:0]};

    // A store mask wins over memtoreg when both are set.
    assign w_is_store = (memwrite_in != 4'b0000);
    assign w_access   = !invalid_in && (memtoreg_in || w_is_store);

    // Lanes shifted past byte 3 are dropped by the 4-bit / 32-bit result width.
    assign w_st_be    = memwrite_in << alu_out_in[1:0];
    assign w_st_wdata = rdata2_in << {alu_out_in[1:0], 3'b000};

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic w_is_half;
    logic w_is_word;
    assign w_is_half  = (inst_data_in[13:12] == 2'b01) || (memwrite_in == 4'b0011);
    assign w_is_word  = (inst_data_in[13:12] == 2'b10) || (memwrite_in == 4'b1111);
    assign w_misalign = (w_is_half && alu_out_in[0]) ||
                        (w_is_word && (alu_out_in[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue    = (state_q == IDLE) && w_access && !w_misalign;
    assign w_complete = ((state_q == REQ) && dmem_req_ready && we_q) ||
                        ((state_q == WAIT) && dmem_rsp_valid);

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        case (state_q)
            IDLE: begin
                if (w_issue) begin
                    state_d     = REQ;
                    req_valid_d = 1'b1;
                    addr_d      = {alu_out_in[31:2], 2'b00};
                    we_d        = w_is_store;
                    be_d        = w_is_store ? w_st_be : 4'b1111;
                    wdata_d     = w_is_store ? w_st_wdata : 32'h0000_0000;
                    funct3_d    = inst_data_in[14:12];
                    off_d       = alu_out_in[1:0];
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = we_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            addr_q      <= 32'h0000_0000;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0000_0000;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
        end
    end

    assign w_rd_shift = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        w_rd_ext = w_rd_shift;
        case (funct3_q)
            3'b000:  w_rd_ext = {{24{w_rd_shift[7]}},  w_rd_shift[7:0]};
            3'b001:  w_rd_ext = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            3'b100:  w_rd_ext = {24'h000000, w_rd_shift[7:0]};
            3'b101:  w_rd_ext = {16'h0000,   w_rd_shift[15:0]};
            default: w_rd_ext = w_rd_shift;
        endcase
    end

    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = addr_q;
    assign dmem_we        = we_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;

    // Combinational outputs are masked while reset is asserted because the
    // synchronous reset has not yet returned the FSM to IDLE.
    assign stall_out      = !reset && !w_complete &&
                            (w_issue || (state_q == REQ) || (state_q == WAIT));
    assign load_valid_out = !reset && (state_q == WAIT) && dmem_rsp_valid;
    assign load_data_out  = load_valid_out ? w_rd_ext : 32'h0000_0000;
    assign misaligned_out = !reset && (state_q == IDLE) && w_access && w_misalign;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit
//   Directed self-checking bench for mem_access_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        invalid_in;
    logic        memtoreg_in;
    logic [3:0]  memwrite_in;
    logic [31:0] alu_out_in;
    logic [31:0] rdata2_in;
    logic [31:0] inst_data_in;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic        load_valid_out;
    logic [31:0] load_data_out;
    logic        misaligned_out;

    int checks   = 0;
    int failures = 0;

    mem_access_unit u_dut (
        .clk            (clk),
        .reset          (reset),
        .invalid_in     (invalid_in),
        .memtoreg_in    (memtoreg_in),
        .memwrite_in    (memwrite_in),
        .alu_out_in     (alu_out_in),
        .rdata2_in      (rdata2_in),
        .inst_data_in   (inst_data_in),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .stall_out      (stall_out),
        .load_valid_out (load_valid_out),
        .load_data_out  (load_data_out),
        .misaligned_out (misaligned_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        invalid_in   = 1'b1;
        memtoreg_in  = 1'b0;
        memwrite_in  = 4'b0000;
        alu_out_in   = 32'h0;
        rdata2_in    = 32'h0;
        inst_data_in = 32'h0;
    endtask

    task automatic drive(input logic ld, input logic [3:0] mask, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] f3);
        invalid_in   = 1'b0;
        memtoreg_in  = ld;
        memwrite_in  = mask;
        alu_out_in   = addr;
        rdata2_in    = data;
        inst_data_in = {17'h0, f3, 12'h0};
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                            input logic [2:0] f3, input int nstall,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        drive(1'b0, mask, addr, data, f3);
        #1;
        check("st_idle_stall", 32'(stall_out), 32'd1);
        check("st_idle_reqv", 32'(dmem_req_valid), 32'd0);
        step();
        bubble();
        for (int i = 0; i < nstall; i++) begin
            dmem_req_ready = 1'b0;
            #1;
            check("st_hold_reqv", 32'(dmem_req_valid), 32'd1);
            check("st_hold_stall", 32'(stall_out), 32'd1);
            step();
        end
        dmem_req_ready = 1'b1;
        #1;
        check("st_reqv", 32'(dmem_req_valid), 32'd1);
        check("st_we", 32'(dmem_we), 32'd1);
        check("st_be", 32'(dmem_be), 32'(exp_be));
        check("st_addr", dmem_addr, {addr[31:2], 2'b00});
        check("st_wdata", dmem_wdata, exp_wd);
        check("st_done_stall", 32'(stall_out), 32'd0);
        step();
        #1;
        check("st_after_reqv", 32'(dmem_req_valid), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input int nstall,
                           input int ndelay, input logic [31:0] rdata, input logic [31:0] exp);
        drive(1'b1, 4'b0000, addr, 32'h0, f3);
        #1;
        check("ld_idle_stall", 32'(stall_out), 32'd1);
        step();
        bubble();
        for (int i = 0; i < nstall; i++) begin
            dmem_req_ready = 1'b0;
            #1;
            check("ld_hold_reqv", 32'(dmem_req_valid), 32'd1);
            step();
        end
        dmem_req_ready = 1'b1;
        #1;
        check("ld_reqv", 32'(dmem_req_valid), 32'd1);
        check("ld_we", 32'(dmem_we), 32'd0);
        check("ld_be", 32'(dmem_be), 32'hF);
        check("ld_addr", dmem_addr, {addr[31:2], 2'b00});
        check("ld_req_stall", 32'(stall_out), 32'd1);
        step();
        for (int i = 0; i < ndelay; i++) begin
            dmem_rsp_valid = 1'b0;
            #1;
            check("ld_wait_stall", 32'(stall_out), 32'd1);
            check("ld_wait_lv", 32'(load_valid_out), 32'd0);
            check("ld_wait_reqv", 32'(dmem_req_valid), 32'd0);
            step();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rdata;
        #1;
        check("ld_lv", 32'(load_valid_out), 32'd1);
        check("ld_data", load_data_out, exp);
        check("ld_done_stall", 32'(stall_out), 32'd0);
        step();
        dmem_rsp_valid = 1'b0;
        #1;
        check("ld_after_lv", 32'(load_valid_out), 32'd0);
        check("ld_after_stall", 32'(stall_out), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        bubble();
        step();
        step();
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_reqv", 32'(dmem_req_valid), 32'd0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_be", 32'(dmem_be), 32'h0);
        reset = 1'b0;
        dmem_req_ready = 1'b1;
        step();

        // Stray response and ready while idle must be ignored.
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h1234_5678;
        #1;
        check("idle_rsp_lv", 32'(load_valid_out), 32'd0);
        check("idle_rsp_stall", 32'(stall_out), 32'd0);
        step();
        dmem_rsp_valid = 1'b0;

        do_store(32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 3'b010, 0, 4'b1111, 32'hDEAD_BEEF);
        do_store(32'h0000_0103, 4'b0001, 32'h0000_00AB, 3'b000, 0, 4'b1000, 32'hAB00_0000);
        do_store(32'h0000_0102, 4'b0011, 32'h0000_1234, 3'b001, 2, 4'b1100, 32'h1234_0000);

        do_load(32'h0000_0102, 3'b000, 0, 3, 32'h0080_FF00, 32'hFFFF_FF80);
        do_load(32'h0000_0102, 3'b100, 2, 0, 32'h0080_FF00, 32'h0000_0080);
        do_load(32'h0000_0200, 3'b010, 0, 1, 32'hCAFE_BABE, 32'hCAFE_BABE);
        do_load(32'h0000_0202, 3'b001, 0, 0, 32'h8001_0000, 32'hFFFF_8001);
        do_load(32'h0000_0202, 3'b101, 0, 0, 32'h8001_0000, 32'h0000_8001);

        // Reset while a load is waiting, with the response landing on and after it.
        drive(1'b1, 4'b0000, 32'h0000_0300, 32'h0, 3'b010);
        step();
        bubble();
        step();
        reset          = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h5555_AAAA;
        #1;
        check("rw_rst_lv", 32'(load_valid_out), 32'd0);
        check("rw_rst_ld", load_data_out, 32'h0);
        check("rw_rst_stall", 32'(stall_out), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rw_post_lv", 32'(load_valid_out), 32'd0);
        check("rw_post_stall", 32'(stall_out), 32'd0);
        check("rw_post_reqv", 32'(dmem_req_valid), 32'd0);
        check("rw_post_addr", dmem_addr, 32'h0);
        check("rw_post_we", 32'(dmem_we), 32'd0);
        check("rw_post_be", 32'(dmem_be), 32'h0);
        check("rw_post_wdata", dmem_wdata, 32'h0);
        check("rw_post_mis", 32'(misaligned_out), 32'd0);
        step();
        dmem_rsp_valid = 1'b0;
        #1;
        check("rw_idle_lv", 32'(load_valid_out), 32'd0);

        // Bubble carrying a store mask must not access memory.
        invalid_in  = 1'b1;
        memwrite_in = 4'b1111;
        alu_out_in  = 32'h0000_0400;
        #1;
        check("inv_stall", 32'(stall_out), 32'd0);
        step();
        bubble();
        #1;
        check("inv_reqv", 32'(dmem_req_valid), 32'd0);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        drive(1'b1, 4'b0000, 32'h0000_0101, 32'h0, 3'b001);
        #1;
        check("mis_flag", 32'(misaligned_out), 32'd1);
        check("mis_stall", 32'(stall_out), 32'd0);
        step();
        bubble();
        #1;
        check("mis_reqv", 32'(dmem_req_valid), 32'd0);
        check("mis_clear", 32'(misaligned_out), 32'd0);
        check("mis_stall2", 32'(stall_out), 32'd0);
`else
        drive(1'b1, 4'b0000, 32'h0000_0101, 32'h0, 3'b001);
        #1;
        check("mis_off_flag", 32'(misaligned_out), 32'd0);
        bubble();
        do_load(32'h0000_0101, 3'b001, 0, 0, 32'h12AB_CD34, 32'hFFFF_ABCD);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 invalid_in  in  1  EX/MEM slot is a bubble; no access.
REQ-004 memtoreg_in  in  1  slot is a load.
REQ-005 memwrite_in  in  4  unshifted store mask: 0001 byte, 0011 half, 1111 word; 0000 means not a store.
REQ-006 alu_out_in  in  32  effective byte address.
REQ-007 rdata2_in  in  32  unshifted store data in low lanes.
REQ-008 inst_data_in  in  32  instruction; funct3 is bits [14:12].
REQ-009 dmem_req_valid  out  1  bus request valid; registered.
REQ-010 dmem_req_ready  in  1  bus accepts the request.
REQ-011 dmem_addr  out  32  word address: alu_out_in with bits [1:0] forced to 0; registered.
REQ-012 dmem_we / dmem_be / dmem_wdata  out  1/4/32  write flag, lane-shifted byte enables, lane-shifted data; registered.
REQ-013 dmem_rsp_valid / dmem_rdata  in  1/32  read response and data.
REQ-014 stall_out  out  1  hold EX/MEM and earlier stages.
REQ-015 load_valid_out / load_data_out  out  1/32  load complete, extended result.
REQ-016 misaligned_out  out  1  misaligned-access flag.

Function
REQ-017 The access signal SHALL be !invalid_in && (memtoreg_in || memwrite_in!=0); when both load and store are indicated, the store SHALL win and the load SHALL be ignored.
REQ-018 The FSM SHALL have states IDLE, REQ and WAIT: IDLE+access -> REQ, latching the bus fields, funct3 and addr[1:0]; REQ+ready+store -> IDLE; REQ+ready+load -> WAIT; WAIT+rsp_valid -> IDLE.
REQ-019 dmem_req_valid SHALL be 1 exactly while in REQ, and the bus fields SHALL stay stable until the handshake.
REQ-020 Stores SHALL shift dmem_be = memwrite_in << addr[1:0], truncated to 4 bits, and dmem_wdata = rdata2_in << 8*addr[1:0]; dmem_we=1.
REQ-021 Loads SHALL drive dmem_we=0 and dmem_be=1111.
REQ-022 The completion cycle SHALL be REQ&ready&store or WAIT&rsp_valid; stall_out = (IDLE&access) | REQ | WAIT, forced to 0 in the completion cycle.
REQ-023 load_valid_out SHALL be combinational and high only in the WAIT&rsp_valid cycle; load_data_out SHALL be dmem_rdata >> 8*offset, then extended per funct3: 000 sign-extend byte, 001 sign-extend half, 100 zero-extend byte, 101 zero-extend half, all other values full word.
REQ-024 Minimum latency SHALL be 2 cycles for stores (IDLE, REQ) and 3 cycles for loads (IDLE, REQ, WAIT); ready and rsp_valid stalls SHALL extend latency without limit.
REQ-025 dmem_rsp_valid SHALL be ignored outside WAIT, and dmem_req_ready SHALL be ignored outside REQ.
REQ-026 Accesses SHALL only be sampled in IDLE, so back-to-back accesses each pass through IDLE.

Reset
REQ-027 Reset SHALL force IDLE, clear dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata and the latched fields to 0, and abandon any in-flight REQ or WAIT.
REQ-028 During reset, stall_out, load_valid_out, load_data_out and misaligned_out SHALL all be 0.
REQ-029 A response arriving after reset SHALL be discarded.

Configuration
REQ-030 The macro MEM_ACCESS_MISALIGN_TRAP_EN SHALL compile misalignment detection in or out.
REQ-031 With MEM_ACCESS_MISALIGN_TRAP_EN defined, misalignment SHALL be detected in IDLE for: half accesses (funct3[1:0]=01 or mask 0011) with addr[0]=1, and word accesses with addr[1:0]!=0.
REQ-032 With MEM_ACCESS_MISALIGN_TRAP_EN defined, a misaligned access SHALL make misaligned_out pulse 1 for that IDLE cycle, issue no bus request, keep stall_out=0 and keep the FSM in IDLE.
REQ-033 Without MEM_ACCESS_MISALIGN_TRAP_EN, misaligned_out SHALL be tied 0, and misaligned accesses SHALL proceed per REQ-020/023 with out-of-word lanes dropped.

Verification
REQ-034 SW addr 0x100, data 0xDEADBEEF, ready=1 -> req_valid in cycle 2 with be=1111, addr=0x100, we=1; stall_out 1,0.
REQ-035 SB addr 0x103, data 0x000000AB -> be=1000, wdata=0xAB000000.
REQ-036 LB addr 0x102, rdata 0x0080FF00, rsp after 3 wait cycles -> stall held; load_data_out=0xFFFFFF80 with load_valid_out for 1 cycle; LBU -> 0x00000080.
REQ-037 LW issued, reset asserted in WAIT, rsp_valid the next cycle -> FSM in IDLE, load_valid_out=0, all outputs 0.
REQ-038 LH addr 0x101 with MEM_ACCESS_MISALIGN_TRAP_EN defined -> misaligned_out=1 for 1 cycle, no req_valid, stall_out=0.
REQ-039 invalid_in=1 with memwrite_in=1111 -> no request and stall_out=0.
